index_2_one_hot_grant: RTL
==========================

INDEX_2_ONE_HOT_GRANT -- requirements
Module: index_2_one_hot_grant

Interface
REQ-001 SHALL have parameter NUM_BITS, default 4, number of one-hot output bits (>=2).
REQ-002 SHALL have parameter INDEX_SIZE, default $clog2(NUM_BITS), input index width.
REQ-003 SHALL have parameter LEN_WIDTH, default 4, hold-length counter width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  input  1  index request valid.
REQ-007 SHALL have port in_ready  output  1  block can accept request this cycle.
REQ-008 SHALL have port in_index  input  INDEX_SIZE  index to decode.
REQ-009 SHALL have port in_len  input  LEN_WIDTH  number of flits the grant is held for.
REQ-010 SHALL have port flit_valid  input  1  consumer moved one flit under the current grant.
REQ-011 SHALL have port one_hot_output  output  NUM_BITS  registered one-hot grant.
REQ-012 SHALL have port grant_active  output  1  a grant is held.
REQ-013 SHALL have port last_flit  output  1  the current flit is the final one of the grant.
REQ-014 SHALL have port err_clear  input  1  clears err_sticky.
REQ-015 SHALL have port err_sticky  output  1  an out-of-range index was seen.

Function
REQ-016 SHALL use two states: IDLE (no grant) and GRANT (one_hot_output held).
REQ-017 SHALL accept a request on a cycle where in_valid && in_ready.
REQ-018 SHALL drive in_ready = 1 in IDLE, and in GRANT only when flit_valid && remaining==1 (back-to-back).
REQ-019 SHALL register one_hot_output = (1 << in_index) on accept, visible the cycle after accept (latency 1).
REQ-020 SHALL load remaining = in_len on accept, with in_len==0 treated as 1.
REQ-021 SHALL decrement remaining by 1 on each flit_valid in GRANT.
REQ-022 SHALL ignore flit_valid in IDLE.
REQ-023 SHALL go GRANT->IDLE and clear one_hot_output to 0 when flit_valid && remaining==1 with no accept that cycle.
REQ-024 SHALL, when flit_valid && remaining==1 coincides with an accept, stay in GRANT and load the new index and length with no idle cycle.
REQ-025 SHALL drive grant_active = (state==GRANT).
REQ-026 SHALL drive last_flit = grant_active && remaining==1, combinational from registered state.
REQ-027 SHALL keep one_hot_output at exactly zero or one bit set at all times.
REQ-028 SHALL hold one_hot_output, remaining and state stable while in_valid is high and in_ready is low; the request is neither accepted nor lost.

Reset
REQ-029 SHALL, while rst_n==0, force state=IDLE, one_hot_output=0, remaining=0, grant_active=0, last_flit=0 and err_sticky=0, immediately and without clk.
REQ-030 SHALL, on reset asserted mid-grant, abandon the grant; after rst_n deasserts, in_ready=1 on the first edge.

Configuration
REQ-031 SHALL, with macro INDEX_2_ONE_HOT_RANGE_CHECK_EN defined, drop any accepted request with in_index >= NUM_BITS: state and outputs unchanged, err_sticky set next cycle and held until err_clear (set wins over simultaneous clear).
REQ-032 SHALL, without INDEX_2_ONE_HOT_RANGE_CHECK_EN, tie err_sticky to 0 and ignore err_clear; an out-of-range index is granted with one_hot_output = 0 for its full length.

Verification
REQ-033 SHALL cover single grant: NUM_BITS=4, accept index 2 with len 3 -> next cycle one_hot_output=4'b0100; stays for 3 flit_valid pulses, last_flit on the 3rd; 4'b0000 after.
REQ-034 SHALL cover back-to-back: index 1/len 1 then index 3/len 2, with the second in_valid on the last flit -> output goes 0010 -> 1000 with no zero cycle.
REQ-035 SHALL cover zero length: index 0 with len 0 -> held for exactly one flit_valid.
REQ-036 SHALL cover backpressure: in_valid held during a 3-flit grant -> in_ready=0 until the 3rd flit; request accepted then; no output change before.
REQ-037 SHALL cover reset mid-grant: rst_n low during remaining==2 -> outputs 0 asynchronously; after release, a new index 3 is accepted and yields 1000.
REQ-038 SHALL cover range check: NUM_BITS=3, index 3 -> with macro, err_sticky=1 and no grant, and err_clear clears it; without macro, grant_active=1 with one_hot_output=3'b000.

Source files
------------

// File: rtl/index_2_one_hot_grant.sv
// Index-to-one-hot grant holder: decodes an accepted index into a registered one-hot
// grant held for in_len flits. Optional range check enabled by INDEX_2_ONE_HOT_RANGE_CHECK_EN.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no grant held, ready for a request
// GRANT | one_hot_output held, counting flits down to 1
module index_2_one_hot_grant #(
  parameter int NUM_BITS   = 4,
  parameter int INDEX_SIZE = $clog2(NUM_BITS),
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INDEX_SIZE-1:0] in_index,
  input  logic [LEN_WIDTH-1:0]  in_len,
  input  logic                  flit_valid,
  output logic [NUM_BITS-1:0]   one_hot_output,
  output logic                  grant_active,
  output logic                  last_flit,
  input  logic                  err_clear,
  output logic                  err_sticky
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [NUM_BITS-1:0]   one_hot_q, one_hot_d;
  logic [NUM_BITS-1:0]   decoded;
  logic [LEN_WIDTH-1:0]  len_eff;
  logic                  end_flit;
  logic                  accept;
  logic                  take;
  logic                  idx_ok;

  // An index outside NUM_BITS simply matches no bit, giving an all-zero grant.
  always_comb begin
    decoded = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      decoded[i] = (int'(in_index) == i);
    end
  end

  assign len_eff  = (in_len == '0) ? LEN_WIDTH'(1) : in_len;
  assign end_flit = (state_q == GRANT) && flit_valid && (remaining_q == LEN_WIDTH'(1));
  assign in_ready = (state_q == IDLE) || end_flit;
  assign accept   = in_valid && in_ready;
  assign take     = accept && idx_ok;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    one_hot_d   = one_hot_q;
    if ((state_q == GRANT) && flit_valid) begin
      remaining_d = remaining_q - LEN_WIDTH'(1);
      if (end_flit) begin
        state_d   = IDLE;
        one_hot_d = '0;
      end
    end
    // A new grant taken on the final flit overrides the release: no idle gap.
    if (take) begin
      state_d     = GRANT;
      one_hot_d   = decoded;
      remaining_d = len_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      one_hot_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      one_hot_q   <= one_hot_d;
    end
  end

  assign one_hot_output = one_hot_q;
  assign grant_active   = (state_q == GRANT);
  assign last_flit      = grant_active && (remaining_q == LEN_WIDTH'(1));

`ifdef INDEX_2_ONE_HOT_RANGE_CHECK_EN
  logic err_q;

  assign idx_ok = (int'(in_index) < NUM_BITS);

  // Setting has priority over a coincident clear so no error is ever missed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept && !idx_ok) begin
      err_q <= 1'b1;
    end else if (err_clear) begin
      err_q <= 1'b0;
    end
  end

  assign err_sticky = err_q;
`else
  logic unused_err_clear;

  assign idx_ok           = 1'b1;
  assign err_sticky       = 1'b0;
  assign unused_err_clear = err_clear;
`endif

endmodule
